// File: rtl/pwm_speed_ramp.sv
// Soft-start speed controller for the PWM stage. It synchronises and debounces the raw
// speed/enable switches, then walks the applied speed one step at a time toward the request.
module pwm_speed_ramp #(
    parameter int SPEED_W         = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [SPEED_W-1:0] req_speed_i,
    input  logic               req_enable_i,
    output logic [SPEED_W-1:0] speed_o,
    output logic               enable_o,
    output logic               busy_o,
    output logic               at_target_o
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DW-1:0]      DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]      TIMER_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        HOLD
    } state_t;

    logic [SPEED_W:0]   syncA_q, syncB_q, cand_q;
    logic [DW-1:0]      debCnt_q;
    logic               tgtEn_q;
    logic [SPEED_W-1:0] tgtSpeed_q;

    state_t             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               enable_q, enable_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic               stepDue;
    logic [SPEED_W-1:0] speedInc, speedDec;

    // A request only becomes the target after the synchronised value has held still long enough.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            syncA_q    <= '0;
            syncB_q    <= '0;
            cand_q     <= '0;
            debCnt_q   <= '0;
            tgtEn_q    <= 1'b0;
            tgtSpeed_q <= '0;
        end else begin
            syncA_q <= {req_enable_i, req_speed_i};
            syncB_q <= syncA_q;
            if (syncB_q != cand_q) begin
                cand_q   <= syncB_q;
                debCnt_q <= '0;
            end else if (debCnt_q == DEB_LAST) begin
                tgtEn_q    <= cand_q[SPEED_W];
                tgtSpeed_q <= cand_q[SPEED_W] ? cand_q[SPEED_W-1:0] : '0;
            end else begin
                debCnt_q <= debCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            speed_q  <= '0;
            enable_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            enable_q <= enable_d;
            timer_q  <= timer_d;
        end
    end

    assign stepDue  = (timer_q == TIMER_LAST);
    assign speedInc = (speed_q != SPEED_MAX) ? speed_q + 1'b1 : speed_q;
    assign speedDec = (speed_q != '0) ? speed_q - 1'b1 : speed_q;

    // Direction reversals take priority over a pending step so a re-enable never dips to zero.
    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        enable_d = enable_q;
        timer_d  = '0;
        case (state_q)
            IDLE: begin
                if (tgtEn_q) begin
                    enable_d = 1'b1;
                    state_d  = (tgtSpeed_q != '0) ? RAMP_UP : HOLD;
                end
            end
            RAMP_UP: begin
                if (tgtSpeed_q < speed_q) begin
                    state_d = RAMP_DOWN;
                end else if (tgtSpeed_q == speed_q) begin
                    state_d = HOLD;
                end else if (stepDue) begin
                    speed_d = speedInc;
                    if (speedInc == tgtSpeed_q) begin
                        state_d = HOLD;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RAMP_DOWN: begin
                if (tgtSpeed_q > speed_q) begin
                    state_d = RAMP_UP;
                end else if (tgtSpeed_q == speed_q) begin
                    if (!tgtEn_q && speed_q == '0) begin
                        state_d  = IDLE;
                        enable_d = 1'b0;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (stepDue) begin
                    speed_d = speedDec;
                    if (speedDec == tgtSpeed_q) begin
                        if (!tgtEn_q && speedDec == '0) begin
                            state_d  = IDLE;
                            enable_d = 1'b0;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                if (tgtSpeed_q > speed_q) begin
                    state_d = RAMP_UP;
                end else if (tgtSpeed_q < speed_q) begin
                    state_d = RAMP_DOWN;
                end else if (!tgtEn_q && speed_q == '0) begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                speed_d  = '0;
                enable_d = 1'b0;
            end
        endcase
    end

    assign speed_o     = speed_q;
    assign enable_o    = enable_q;
    assign busy_o      = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    assign at_target_o = !busy_o && (speed_q == tgtSpeed_q);

endmodule

// File: tb/tb_pwm_speed_ramp.sv
// Bench for pwm_speed_ramp: directed soft-start scenarios plus randomized switch activity,
// all checked every cycle against a behavioural model of the debounce window and speed walk.
module tb_pwm_speed_ramp;

    localparam int SW   = 3;
    localparam int DEB  = 4;
    localparam int STEP = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [SW-1:0] reqSpeed = '0;
    logic          reqEnable = 1'b0;
    logic [SW-1:0] speed;
    logic          enable, busy, atTarget;

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    pwm_speed_ramp #(.SPEED_W(SW), .DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(STEP)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .req_speed_i  (reqSpeed),
        .req_enable_i (reqEnable),
        .speed_o      (speed),
        .enable_o     (enable),
        .busy_o       (busy),
        .at_target_o  (atTarget)
    );

    always #5 clock = ~clock;

    // Model state: the last few sampled switch values, the accepted target, and the walk itself
    // (running flag, current speed, direction of travel and cycles since the last move).
    logic [SW:0] hist [0:DEB+2];
    int  mTgt = 0, mSpd = 0, mDir = 0, mCnt = 0, want;
    bit  mTgtEn = 1'b0, mEn = 1'b0, stable;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mTgt = 0; mSpd = 0; mDir = 0; mCnt = 0;
            mTgtEn = 1'b0; mEn = 1'b0;
            for (int j = 0; j <= DEB + 2; j++) hist[j] = '0;
        end else begin
            if (!mEn) begin
                if (mTgtEn) begin
                    mEn = 1'b1;
                    mDir = (mTgt > 0) ? 1 : 0;
                    mCnt = 0;
                end
            end else if (mDir == 0) begin
                if (mTgt != mSpd) begin
                    mDir = (mTgt > mSpd) ? 1 : -1;
                    mCnt = 0;
                end else if (!mTgtEn && mSpd == 0) begin
                    mEn = 1'b0;
                end
            end else begin
                want = (mTgt > mSpd) ? 1 : (mTgt < mSpd) ? -1 : 0;
                if (want == 0) begin
                    if (mDir == -1 && !mTgtEn && mSpd == 0) mEn = 1'b0;
                    mDir = 0;
                end else if (want != mDir) begin
                    mDir = want;
                    mCnt = 0;
                end else if (mCnt == STEP - 1) begin
                    mSpd = mSpd + mDir;
                    if (mSpd > (1 << SW) - 1) mSpd = (1 << SW) - 1;
                    if (mSpd < 0) mSpd = 0;
                    mCnt = 0;
                    if (mSpd == mTgt) begin
                        if (mDir == -1 && !mTgtEn && mSpd == 0) mEn = 1'b0;
                        mDir = 0;
                    end
                end else begin
                    mCnt++;
                end
            end
            // A value is accepted once it has been seen through the synchroniser DEB+1 times in a row.
            for (int j = DEB + 2; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {reqEnable, reqSpeed};
            stable = 1'b1;
            for (int j = 3; j <= DEB + 2; j++) if (hist[j] != hist[2]) stable = 1'b0;
            if (stable) begin
                mTgtEn = hist[2][SW];
                mTgt   = mTgtEn ? int'(hist[2][SW-1:0]) : 0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, outputs are compared with the model midway between rising edges.
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("model speed", int'(speed), mSpd);
            checkOutput("model enable", int'(enable), int'(mEn));
            checkOutput("model busy", int'(busy), int'(mDir != 0));
            checkOutput("model at_target", int'(atTarget), int'(mDir == 0 && mSpd == mTgt));
        end
    end

    task automatic waitEdge();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input bit en, input int spd, input int cycles);
        reqEnable = en;
        reqSpeed  = SW'(spd);
        repeat (cycles) waitEdge();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit dropped;
        // Reset held with a run request already present on the switches.
        reqEnable = 1'b1;
        reqSpeed  = 3'd5;
        repeat (3) waitEdge();
        checkOutput("reset speed", int'(speed), 0);
        checkOutput("reset enable", int'(enable), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset at_target", int'(atTarget), 1);
        @(negedge clock);
        reset = 1'b0;
        checkEn = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            waitEdge();
            if (i == 7)  checkOutput("enable before edge 8", int'(enable), 0);
            if (i == 8)  checkOutput("enable at edge 8", int'(enable), 1);
            if (i == 8)  checkOutput("busy at ramp entry", int'(busy), 1);
            if (i == 15) checkOutput("speed before first step", int'(speed), 0);
            if (i == 16) checkOutput("first step", int'(speed), 1);
            if (i == 47) checkOutput("speed before last step", int'(speed), 4);
        end
        checkOutput("ramp end speed", int'(speed), 5);
        checkOutput("ramp end busy", int'(busy), 0);
        checkOutput("ramp end at_target", int'(atTarget), 1);

        // Short glitches on the speed switches must never become the target.
        applyStimulus(1, 2, 2);
        applyStimulus(1, 5, 2);
        applyStimulus(1, 2, 2);
        applyStimulus(1, 5, 20);
        checkOutput("glitch speed", int'(speed), 5);
        checkOutput("glitch busy", int'(busy), 0);

        // Ramp down toward 2, reversed upward to 7 once speed reaches 4.
        applyStimulus(1, 2, 0);
        for (int i = 0; i < 200 && speed != 3'd4; i++) waitEdge();
        checkOutput("reached 4", int'(speed), 4);
        applyStimulus(1, 7, 0);
        for (int i = 0; i < 200 && !(speed == 3'd7 && !busy); i++) waitEdge();
        checkOutput("reached 7", int'(speed), 7);

        // Settle at 3, drop enable, then re-enable at speed 1 with no stop in between.
        applyStimulus(1, 3, 0);
        for (int i = 0; i < 300 && !(speed == 3'd3 && !busy); i++) waitEdge();
        checkOutput("settled 3", int'(speed), 3);
        applyStimulus(0, 3, 0);
        for (int i = 0; i < 200 && speed != 3'd1; i++) waitEdge();
        checkOutput("down to 1", int'(speed), 1);
        applyStimulus(1, 3, 0);
        dropped = 1'b0;
        for (int i = 0; i < 300 && !(speed == 3'd3 && !busy); i++) begin
            waitEdge();
            if (!enable) dropped = 1'b1;
        end
        checkOutput("re-enable kept running", int'(dropped), 0);
        checkOutput("back at 3", int'(speed), 3);

        // Disable fully: enable must fall on the same edge speed reaches 0.
        applyStimulus(0, 3, 0);
        for (int i = 0; i < 300 && speed != 3'd0; i++) waitEdge();
        checkOutput("stopped speed", int'(speed), 0);
        checkOutput("enable falls with speed 0", int'(enable), 0);

        // Asynchronous reset in the middle of a ramp.
        applyStimulus(1, 7, 0);
        for (int i = 0; i < 300 && speed != 3'd3; i++) waitEdge();
        checkOutput("mid ramp busy", int'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset speed", int'(speed), 0);
        checkOutput("async reset enable", int'(enable), 0);
        checkOutput("async reset busy", int'(busy), 0);

        // Enable with zero speed goes straight to a running hold.
        reqEnable = 1'b1;
        reqSpeed  = 3'd0;
        @(negedge clock);
        reset = 1'b0;
        repeat (12) waitEdge();
        checkOutput("zero hold enable", int'(enable), 1);
        checkOutput("zero hold speed", int'(speed), 0);
        checkOutput("zero hold busy", int'(busy), 0);
        checkOutput("zero hold at_target", int'(atTarget), 1);

        // Randomized switch activity, with one asynchronous reset pulse partway through.
        for (int seg = 0; seg < 60; seg++) begin
            if (seg == 30) begin
                #3 reset = 1'b1;
                #10 reset = 1'b0;
                waitEdge();
            end
            applyStimulus($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(1, 40));
        end
        applyStimulus(1, 7, 80);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
